// File: rtl/toy_bus_age_arb.sv
// toy_bus_age_arb: oldest-first N-input arbiter for a toy_bus egress port.
// The age matrix orders requesters by arrival, and the grant is locked for the whole of a multi-beat packet.
module toy_bus_age_arb #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_vld,
    input  logic [N-1:0]  in_last,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]  in_rdy,
    output logic          out_vld,
    output logic          out_last,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_src,
    input  logic          out_rdy
);
    localparam int NP = N * (N - 1) / 2;

    // Position of older[i][j] (i<j) in the packed upper triangle
    function automatic int pidx(input int i, input int j);
        return i * N - i * (i + 1) / 2 + j - i - 1;
    endfunction

    logic [N-1:0]  active_q;
    logic          lock_q;
    logic [IW-1:0] lock_idx_q;
    logic [NP-1:0] age_q;
    logic [N-1:0]  arrive, elig, win, done;
    logic [N-1:0]  older [N];
    logic [IW-1:0] sel_u, sel;
    logic          fire;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (i < j) begin : g_up
                assign older[i][j] = age_q[pidx(i, j)];
            end else if (i > j) begin : g_lo
                assign older[i][j] = ~age_q[pidx(j, i)];
            end else begin : g_diag
                assign older[i][j] = 1'b1;
            end
        end
        assign win[i] = elig[i] & (&(older[i] | ~elig));
    end

    always_comb begin
        arrive = in_vld & ~active_q;
        elig   = active_q & in_vld;
        sel_u  = '0;
        for (int i = 0; i < N; i++)
            if (win[i]) sel_u = IW'(i);
        sel      = lock_q ? lock_idx_q : sel_u;
        out_vld  = lock_q ? in_vld[lock_idx_q] : |elig;
        out_src  = sel;
        out_last = in_last[sel];
        out_data = in_data[sel*DW +: DW];
        fire     = out_vld & out_rdy;
        in_rdy   = fire ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
        done     = in_rdy & in_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            age_q      <= '0;
        end else begin
            active_q <= arrive | (active_q & ~done);
            if (fire) begin
                lock_q     <= ~out_last;
                lock_idx_q <= sel;
            end
            // A newcomer is younger than every active requester and older than every idle one
            for (int i = 0; i < N; i++)
                for (int j = i + 1; j < N; j++)
                    if (arrive[i] & arrive[j])
                        age_q[pidx(i, j)] <= 1'b1;
                    else if (arrive[i])
                        age_q[pidx(i, j)] <= ~active_q[j];
                    else if (arrive[j])
                        age_q[pidx(i, j)] <= active_q[i];
        end
    end
endmodule
